line_xfer_engine: RTL

Line transfer engine between the cache data array and the external memory bus. It refills one array line from a narrow beat stream, or evicts one array line as a beat stream. It drives the array's read and write ports directly and is the initiator for that interface. Fills are staged so the array sees one atomic full-line write.

---
 rtl/line_xfer_engine_if.sv | 59 +++++
 rtl/line_xfer_engine.sv | 136 +++++++++++++
 2 files changed

// File: rtl/line_xfer_engine_if.sv
// Bundle of the engine's command, memory-beat and array-port signals.
// Ports: master = engine side, slave = command/memory/array side.
interface line_xfer_engine_if #(
    parameter int DW  = 128,
    parameter int NUM = 8,
    parameter int BW  = 32
);
    localparam int BEATS = DW / BW;
    localparam int IW    = $clog2(NUM);
    localparam int WW    = $clog2(BEATS);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [IW-1:0] cmd_idx;
    logic [WW-1:0] cmd_word;

    logic          mem_rvalid;
    logic          mem_rready;
    logic [BW-1:0] mem_rdata;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [BW-1:0] mem_wdata;
    logic          mem_wlast;

    logic            arr_read_en;
    logic [IW-1:0]   arr_read_addr;
    logic [DW-1:0]   arr_read_data;
    logic            arr_write_en;
    logic [DW/8-1:0] arr_write_byte_en;
    logic [IW-1:0]   arr_write_addr;
    logic [DW-1:0]   arr_write_data;

    logic done;

    modport master (
        input  cmd_valid, cmd_op, cmd_idx, cmd_word,
        output cmd_ready,
        input  mem_rvalid, mem_rdata, mem_wready,
        output mem_rready, mem_wvalid, mem_wdata, mem_wlast,
        input  arr_read_data,
        output arr_read_en, arr_read_addr,
        output arr_write_en, arr_write_byte_en,
        output arr_write_addr, arr_write_data,
        output done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_idx, cmd_word,
        input  cmd_ready,
        output mem_rvalid, mem_rdata, mem_wready,
        input  mem_rready, mem_wvalid, mem_wdata, mem_wlast,
        output arr_read_data,
        input  arr_read_en, arr_read_addr,
        input  arr_write_en, arr_write_byte_en,
        input  arr_write_addr, arr_write_data,
        input  done
    );
endinterface

// File: rtl/line_xfer_engine.sv
// Line transfer engine: fills one array line from memory beats (staged,
// single full-line write) or evicts one array line as a beat stream.
// Ports: clk, rst_n (sync, active-low), io (line_xfer_engine_if.master).
// Option: LINE_XFER_CRITICAL_WORD_FIRST_EN starts the beat order at cmd_word.
module line_xfer_engine #(
    parameter int DW  = 128,
    parameter int NUM = 8,
    parameter int BW  = 32
) (
    input logic              clk,
    input logic              rst_n,
    line_xfer_engine_if.master io
);
    localparam int BEATS = DW / BW;
    localparam int CW    = $clog2(BEATS);
    localparam int IW    = $clog2(NUM);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FWRITE,
        EVICT_RD,
        EVICT_TX
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] b_q;
    logic [CW:0]   cnt_q;
    logic [DW-1:0] stage_q;
    logic [CW-1:0] start_w;
    logic          rd_hs;
    logic          wr_hs;
    logic          last_beat;

`ifdef LINE_XFER_CRITICAL_WORD_FIRST_EN
    assign start_w = io.cmd_word;
`else
    logic unused_cmd_word;
    assign unused_cmd_word = ^io.cmd_word;
    assign start_w = '0;
`endif

    assign rd_hs     = (state == FILL) && io.mem_rvalid;
    assign wr_hs     = (state == EVICT_TX) && io.mem_wready;
    assign last_beat = (cnt_q == (CW+1)'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx             = state;
        io.cmd_ready         = 1'b0;
        io.mem_rready        = 1'b0;
        io.mem_wvalid        = 1'b0;
        io.mem_wdata         = '0;
        io.mem_wlast         = 1'b0;
        io.arr_read_en       = 1'b0;
        io.arr_read_addr     = '0;
        io.arr_write_en      = 1'b0;
        io.arr_write_byte_en = '0;
        io.arr_write_addr    = '0;
        io.arr_write_data    = '0;
        io.done              = 1'b0;
        unique case (state)
            IDLE: begin
                // Held off combinationally so nothing is offered during reset.
                io.cmd_ready = rst_n;
                if (io.cmd_valid && rst_n) begin
                    state_nx = io.cmd_op ? EVICT_RD : FILL;
                end
            end
            FILL: begin
                io.mem_rready = 1'b1;
                if (io.mem_rvalid && last_beat) begin
                    state_nx = FWRITE;
                end
            end
            FWRITE: begin
                io.arr_write_en      = 1'b1;
                io.arr_write_byte_en = '1;
                io.arr_write_addr    = idx_q;
                io.arr_write_data    = stage_q;
                io.done              = 1'b1;
                state_nx             = IDLE;
            end
            EVICT_RD: begin
                io.arr_read_en   = 1'b1;
                io.arr_read_addr = idx_q;
                state_nx         = EVICT_TX;
            end
            EVICT_TX: begin
                io.mem_wvalid = 1'b1;
                io.mem_wdata  = stage_q[b_q*BW +: BW];
                io.mem_wlast  = last_beat;
                if (io.mem_wready && last_beat) begin
                    io.done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            if (state == IDLE && io.cmd_valid) begin
                idx_q <= io.cmd_idx;
                b_q   <= start_w;
                cnt_q <= '0;
            end
            if (rd_hs) begin
                stage_q[b_q*BW +: BW] <= io.mem_rdata;
            end
            if (state == EVICT_RD) begin
                stage_q <= io.arr_read_data;
            end
            // Beat index wraps naturally at BEATS (power of two).
            if (rd_hs || wr_hs) begin
                b_q   <= b_q + 1'b1;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule
